// File: rtl/kcpsm6_irq_pkg.sv
// Shared definitions for the KCPSM6 interrupt controller.
//   irq_state_e      : controller FSM states
//   *_PORT_DEF       : default KCPSM6 port_id assignments
//   src_mask8()      : 8-bit mask with the low n bits set (implemented sources)
package kcpsm6_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  localparam logic [7:0] MASK_PORT_DEF = 8'h10;
  localparam logic [7:0] STAT_PORT_DEF = 8'h11;
  localparam logic [7:0] PEND_PORT_DEF = 8'h12;
  localparam logic [7:0] CLR_PORT_DEF  = 8'h13;

  // Bits at index >= n correspond to unimplemented sources and are forced to 0.
  function automatic logic [7:0] src_mask8(input int n);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: returns the first set bit of req, searching upward
// from ptr and wrapping from N-1 back to 0.
//   req   : request vector (N bits)
//   ptr   : starting index of the search (must be < N)
//   valid : at least one request is set
//   index : chosen request index
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         valid,
  output logic [2:0]   index
);

  logic [7:0] req8_s;
  logic [3:0] pos_s;

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    req8_s         = 8'h00;
    req8_s[N-1:0]  = req;
    valid          = 1'b0;
    index          = 3'd0;
    pos_s          = 4'd0;
    for (int k = 0; k < N; k++) begin
      pos_s = {1'b0, ptr} + 4'(k);
      if (pos_s >= 4'(N)) begin
        pos_s = pos_s - 4'(N);
      end else begin
        pos_s = pos_s;
      end
      if (!valid && req8_s[pos_s[2:0]]) begin
        valid = 1'b1;
        index = pos_s[2:0];
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/kcpsm6_irq_ctrl.sv
// Rising-edge interrupt controller for a KCPSM6 soft processor.
//   clk, reset     : clock and asynchronous active-low reset
//   irq_req        : per-source requests, latched on their rising edge
//   port_id, out_port, write_strobe : KCPSM6 I/O write bus
//   rd_data        : registered read data for the in_port multiplexer
//   interrupt      : to KCPSM6 interrupt input
//   interrupt_ack  : from KCPSM6 interrupt_ack
// Registers: MASK (R/W), STAT (RO: in_service, gnt), PEND (RO), CLR (WO,
// end-of-service for the granted source).
module kcpsm6_irq_ctrl
  import kcpsm6_irq_pkg::*;
#(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] MASK_PORT = MASK_PORT_DEF,
  parameter logic [7:0] STAT_PORT = STAT_PORT_DEF,
  parameter logic [7:0] PEND_PORT = PEND_PORT_DEF,
  parameter logic [7:0] CLR_PORT  = CLR_PORT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_req,
  input  logic [7:0]       port_id,
  input  logic [7:0]       out_port,
  input  logic             write_strobe,
  output logic [7:0]       rd_data,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  localparam logic [7:0] SRC_MASK8 = src_mask8(N_SRC);

  irq_state_e       state_r, state_next_s;
  logic [N_SRC-1:0] req_q_r, req_qq_r, edge_s;
  logic             armed_r;
  logic [N_SRC-1:0] pend_r, pend_next_s, clr_mask_s;
  logic [7:0]       mask_r;
  logic [2:0]       gnt_r, rr_ptr_r, rr_next_s;
  logic [3:0]       rr_sum_s;
  logic             interrupt_r, interrupt_next_s;
  logic [7:0]       rd_data_r, rd_next_s, pend8_s;
  logic             arb_valid_s;
  logic [2:0]       arb_idx_s;
  logic             clr_wr_s, clr_s, mask_wr_s, take_s;

  assign edge_s    = req_q_r & ~req_qq_r;
  assign clr_wr_s  = write_strobe && (port_id == CLR_PORT);
  assign mask_wr_s = write_strobe && (port_id == MASK_PORT);
  assign clr_s     = clr_wr_s && (state_r == ST_SERVICE);
  assign take_s    = (state_r == ST_IDLE) && arb_valid_s;
  assign rd_data   = rd_data_r;
  assign interrupt = interrupt_r;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req   (pend_r & mask_r[N_SRC-1:0]),
    .ptr   (rr_ptr_r),
    .valid (arb_valid_s),
    .index (arb_idx_s)
  );

  // Request synchroniser/edge history. The first cycle out of reset loads
  // both stages so a source held high through reset release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q_r  <= '0;
      req_qq_r <= '0;
      armed_r  <= 1'b0;
    end else if (!armed_r) begin
      req_q_r  <= irq_req;
      req_qq_r <= irq_req;
      armed_r  <= 1'b1;
    end else begin
      req_q_r  <= irq_req;
      req_qq_r <= req_q_r;
      armed_r  <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; mask only matters for leaving IDLE.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE:    state_next_s = arb_valid_s   ? ST_ASSERT  : ST_IDLE;
      ST_ASSERT:  state_next_s = interrupt_ack ? ST_SERVICE : ST_ASSERT;
      ST_SERVICE: state_next_s = clr_wr_s      ? ST_IDLE    : ST_SERVICE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values: pend set/clear, round-robin pointer, read mux.
  always_comb begin
    clr_mask_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_mask_s[i] = clr_s && (gnt_r == 3'(i));
    end
    // A new edge on the source being cleared wins over the clear.
    pend_next_s = (pend_r & ~clr_mask_s) | edge_s;

    rr_sum_s = {1'b0, arb_idx_s} + 4'd1;
    if (rr_sum_s >= 4'(N_SRC)) begin
      rr_next_s = 3'd0;
    end else begin
      rr_next_s = rr_sum_s[2:0];
    end

    interrupt_next_s = (state_next_s == ST_ASSERT);

    pend8_s              = 8'h00;
    pend8_s[N_SRC-1:0]   = pend_r;
    case (port_id)
      MASK_PORT: rd_next_s = mask_r;
      STAT_PORT: rd_next_s = {(state_r == ST_SERVICE), 4'b0000, gnt_r};
      PEND_PORT: rd_next_s = pend8_s;
      default:   rd_next_s = 8'h00;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r      <= '0;
      mask_r      <= 8'h00;
      gnt_r       <= 3'd0;
      rr_ptr_r    <= 3'd0;
      interrupt_r <= 1'b0;
      rd_data_r   <= 8'h00;
    end else begin
      pend_r      <= pend_next_s;
      mask_r      <= mask_wr_s ? (out_port & SRC_MASK8) : mask_r;
      gnt_r       <= take_s ? arb_idx_s : gnt_r;
      rr_ptr_r    <= take_s ? rr_next_s : rr_ptr_r;
      interrupt_r <= interrupt_next_s;
      rd_data_r   <= rd_next_s;
    end
  end

endmodule

// File: tb/tb_kcpsm6_irq_ctrl.sv
// Self-checking bench for kcpsm6_irq_ctrl (N_SRC=4): directed scenarios with
// fixed expectations, then randomized traffic against a cycle-level model.
module tb_kcpsm6_irq_ctrl;

  localparam int         N    = 4;
  localparam logic [7:0] PMSK = 8'h10;
  localparam logic [7:0] PSTA = 8'h11;
  localparam logic [7:0] PPND = 8'h12;
  localparam logic [7:0] PCLR = 8'h13;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irq_req = '0;
  logic [7:0]   port_id = 8'h00;
  logic [7:0]   out_port = 8'h00;
  logic         write_strobe = 1'b0;
  logic         interrupt_ack = 1'b0;
  logic [7:0]   rd_data;
  logic         interrupt;

  int n_checks = 0;
  int n_errors = 0;

  kcpsm6_irq_ctrl #(.N_SRC(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_req       (irq_req),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .rd_data       (rd_data),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=idle, 1=interrupt raised, 2=being serviced.
  bit m_s1[N], m_s2[N], m_pend[N], m_mask[N];
  int m_phase, m_gnt, m_ptr, m_rd;
  bit m_irq, m_first;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
    end
    m_phase = 0; m_gnt = 0; m_ptr = 0; m_rd = 0; m_irq = 0; m_first = 1;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_step();
    bit rising[N];
    int pick;
    bit clear;
    int v;
    pick = -1;
    for (int i = 0; i < N; i++) rising[i] = m_s1[i] && !m_s2[i];
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (pick < 0 && m_pend[j] && m_mask[j]) pick = j;
      end
    end
    v = 0;
    if (port_id == PMSK) begin
      for (int i = 0; i < N; i++) if (m_mask[i]) v += (1 << i);
    end else if (port_id == PSTA) begin
      v = (m_phase == 2 ? 128 : 0) + m_gnt;
    end else if (port_id == PPND) begin
      for (int i = 0; i < N; i++) if (m_pend[i]) v += (1 << i);
    end
    m_rd = v;
    clear = (m_phase == 2) && write_strobe && (port_id == PCLR);
    for (int i = 0; i < N; i++)
      m_pend[i] = rising[i] || (m_pend[i] && !(clear && i == m_gnt));
    if (m_phase == 0 && pick >= 0) begin
      m_phase = 1; m_gnt = pick; m_ptr = (pick + 1) % N;
    end else if (m_phase == 1 && interrupt_ack) begin
      m_phase = 2;
    end else if (m_phase == 2 && clear) begin
      m_phase = 0;
    end
    if (write_strobe && port_id == PMSK)
      for (int i = 0; i < N; i++) m_mask[i] = out_port[i];
    m_irq = (m_phase == 1);
    for (int i = 0; i < N; i++) begin
      m_s2[i] = m_first ? irq_req[i] : m_s1[i];
      m_s1[i] = irq_req[i];
    end
    m_first = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model steps on the current inputs, DUT outputs compared after the edge.
  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("irq_model", {31'd0, interrupt}, {31'd0, m_irq});
    chk("rd_model", {24'd0, rd_data}, m_rd);
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id = p; out_port = d; write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_irq", {31'd0, interrupt}, 32'd0);
    chk("rst_rd", {24'd0, rd_data}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    m_reset();
  endtask

  initial begin
    m_reset();
    do_reset();

    // Single request on source 2, full service cycle.
    wr(PMSK, 8'h0F);
    irq_req = 4'b0100; tick();
    irq_req = 4'b0000; tick();
    chk("s35_e1_irq", {31'd0, interrupt}, 32'd0);
    tick();
    chk("s35_e2_irq", {31'd0, interrupt}, 32'd1);
    port_id = PSTA; tick();
    chk("s35_stat_pre", {24'd0, rd_data}, 32'h02);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    chk("s35_ack_irq", {31'd0, interrupt}, 32'd0);
    tick();
    chk("s35_stat_svc", {24'd0, rd_data}, 32'h82);
    wr(PCLR, 8'hA5);
    port_id = PPND; tick();
    chk("s35_pend_clr", {24'd0, rd_data}, 32'h00);

    // Masked source stays pending; unmasking raises the interrupt.
    do_reset();
    wr(PMSK, 8'h00);
    irq_req = 4'b0010; tick();
    irq_req = 4'b0000; tick();
    port_id = PPND; tick();
    chk("s36_pend", {24'd0, rd_data}, 32'h02);
    tick();
    chk("s36_masked_irq", {31'd0, interrupt}, 32'd0);
    wr(PMSK, 8'h02);
    chk("s36_wr_irq", {31'd0, interrupt}, 32'd0);
    tick();
    chk("s36_unmask_irq", {31'd0, interrupt}, 32'd1);

    // Round-robin with wrap.
    do_reset();
    wr(PMSK, 8'h0F);
    irq_req = 4'b1001; tick();
    irq_req = 4'b0000; tick(); tick();
    port_id = PSTA; tick();
    chk("s37_gnt_first", {24'd0, rd_data}, 32'h00);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    wr(PCLR, 8'h00);
    tick();
    port_id = PSTA; tick();
    chk("s37_gnt_second", {24'd0, rd_data}, 32'h03);
    chk("s37_irq_second", {31'd0, interrupt}, 32'd1);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    wr(PCLR, 8'h00);
    irq_req = 4'b0011; tick();
    irq_req = 4'b0000; tick(); tick();
    port_id = PSTA; tick();
    chk("s37_gnt_wrap", {24'd0, rd_data}, 32'h00);

    // Set wins over clear on the granted source; CLR ignored in ASSERT.
    do_reset();
    wr(PMSK, 8'h0F);
    irq_req = 4'b0010; tick();
    irq_req = 4'b0000; tick(); tick();
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    irq_req = 4'b0010; tick();
    irq_req = 4'b0000;
    wr(PCLR, 8'hFF);
    port_id = PPND; tick();
    chk("s38_pend_kept", {24'd0, rd_data}, 32'h02);
    chk("s38_reassert", {31'd0, interrupt}, 32'd1);
    wr(PCLR, 8'h00);
    chk("s40_clr_in_assert", {31'd0, interrupt}, 32'd1);
    tick();
    chk("s40_still_high", {31'd0, interrupt}, 32'd1);
    interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    chk("s40_ack_drop", {31'd0, interrupt}, 32'd0);

    // Asynchronous reset while interrupt is high; source held through release.
    do_reset();
    wr(PMSK, 8'h0F);
    irq_req = 4'b0001; tick();
    irq_req = 4'b0000; tick(); tick();
    chk("s39_pre_irq", {31'd0, interrupt}, 32'd1);
    irq_req = 4'b0100;
    do_reset();
    wr(PMSK, 8'h0F);
    for (int c = 0; c < 6; c++) tick();
    chk("s39_held_irq", {31'd0, interrupt}, 32'd0);
    port_id = PPND; tick();
    chk("s39_held_pend", {24'd0, rd_data}, 32'h00);
    irq_req = 4'b0000; tick();
    irq_req = 4'b0100; tick(); tick(); tick();
    chk("s39_new_edge_irq", {31'd0, interrupt}, 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] ports [6];
      ports[0] = PMSK; ports[1] = PSTA; ports[2] = PPND;
      ports[3] = PCLR; ports[4] = 8'h00; ports[5] = PPND;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) irq_req[i] = ~irq_req[i];
      port_id       = ports[$urandom_range(0, 5)];
      out_port      = 8'($urandom);
      write_strobe  = ($urandom_range(0, 3) == 0);
      interrupt_ack = ($urandom_range(0, 2) == 0);
      tick();
    end
    write_strobe = 1'b0;
    interrupt_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/kcpsm6_irq_ctrl.md
KCPSM6_IRQ_CTRL -- requirements
Module: kcpsm6_irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of interrupt sources, legal range 1..8.
REQ-002 SHALL have parameter MASK_PORT, default 8'h10, port_id of the R/W mask register.
REQ-003 SHALL have parameter STAT_PORT, default 8'h11, port_id of the read-only status register.
REQ-004 SHALL have parameter PEND_PORT, default 8'h12, port_id of the read-only pending register.
REQ-005 SHALL have parameter CLR_PORT, default 8'h13, port_id of the write-only end-of-service port.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port irq_req, input, N_SRC bits: source requests, synchronous to clk, rising-edge sensitive.
REQ-009 SHALL have port port_id, input, 8 bits: KCPSM6 port address.
REQ-010 SHALL have port out_port, input, 8 bits: KCPSM6 write data.
REQ-011 SHALL have port write_strobe, input, 1 bit: KCPSM6 write qualifier.
REQ-012 SHALL have port rd_data, output, 8 bits: registered read data for the in_port multiplexer.
REQ-013 SHALL have port interrupt, output, 1 bit: to the KCPSM6 interrupt input.
REQ-014 SHALL have port interrupt_ack, input, 1 bit: from KCPSM6 interrupt_ack.

Function
REQ-015 SHALL register irq_req into req_q each cycle; edge[i] = req_q[i] & ~req_qq[i].
REQ-016 SHALL set pend[i] on the clock edge after edge[i]; first edge sampling irq_req high = E0, pend visible after E1.
REQ-017 SHALL write mask[N_SRC-1:0] from out_port[N_SRC-1:0] when write_strobe=1 and port_id=MASK_PORT; mask gates arbitration only, never pend setting.
REQ-018 SHALL implement FSM states IDLE, ASSERT, SERVICE.
REQ-019 IDLE->ASSERT when (pend & mask) != 0; the granted index is latched into gnt on this transition; interrupt=1 from the next cycle (after E2 for a single request).
REQ-020 ASSERT SHALL hold interrupt=1 regardless of later mask changes; ASSERT->SERVICE on interrupt_ack=1, interrupt=0 from the next cycle.
REQ-021 SERVICE->IDLE on write_strobe=1 with port_id=CLR_PORT, with pend[gnt] cleared on the same edge; out_port value ignored.
REQ-022 CLR_PORT writes in IDLE or ASSERT SHALL be ignored.
REQ-023 Arbitration SHALL be round-robin: search starts at rr_ptr, ascending index with wrap from N_SRC-1 to 0; rr_ptr <= gnt+1 (mod N_SRC) on IDLE->ASSERT; rr_ptr resets to 0.
REQ-024 If a new edge on source gnt coincides with its clear, set SHALL win and pend[gnt] remains 1.
REQ-025 Edges on a source that is already pending SHALL be absorbed; there is no counting.
REQ-026 rd_data SHALL be registered every cycle from port_id, independent of read_strobe.
REQ-027 rd_data SHALL return {0, mask} for MASK_PORT, {in_service, 4'b0, gnt[2:0]} for STAT_PORT, where in_service = (state==SERVICE), {0, pend} for PEND_PORT, and 8'h00 for any other port_id.
REQ-028 Unused high bits (index >= N_SRC) SHALL read 0 and ignore writes.

Reset
REQ-029 reset=0 SHALL asynchronously force: state=IDLE, interrupt=0, rd_data=8'h00, mask=0, pend=0, gnt=0, rr_ptr=0, req_q=0, req_qq=0.
REQ-030 Reset asserted mid-ASSERT or mid-SERVICE SHALL drop interrupt immediately and discard all pending requests.
REQ-031 A source held high through reset release SHALL NOT register an edge; it requires a low-then-high transition.

Structure
REQ-032 Package kcpsm6_irq_pkg SHALL hold the state enum and the default port address constants.
REQ-033 Round-robin pick logic SHALL be the sub-module rr_arbiter (inputs: req vector, ptr; outputs: valid, index).
REQ-034 The target implementation size is 120-400 lines of RTL.

Verification
REQ-035 N_SRC=4, mask=4'hF, pulse irq_req[2] -> interrupt=1 after E2; STAT reads 8'h02 after ack with 8'h82; CLR write -> PEND reads 8'h00.
REQ-036 mask=4'h0, pulse irq_req[1] -> PEND reads 8'h02, interrupt stays 0; then write mask=4'h2 -> interrupt=1 two cycles later.
REQ-037 irq_req[0] and [3] rise in the same cycle -> first gnt=0, after CLR second gnt=3; next simultaneous 0 and 1 -> gnt=0 (rr_ptr wrapped to 0 after 3).
REQ-038 During SERVICE of source 1, re-pulse irq_req[1] on the same cycle as the CLR write -> PEND bit1 stays 1 and interrupt re-asserts.
REQ-039 Assert reset=0 while interrupt=1 -> interrupt=0 without a clock edge; after release, irq_req[2] held high -> no interrupt.
REQ-040 CLR write while in ASSERT -> ignored, interrupt remains 1 until interrupt_ack.
